fetch_cache_unit: RTL

- Parametrised instruction-fetch front end: PC register, direct-mapped instruction cache with valid/tag arrays, and a miss FSM with a req/ack handshake to the instruction memory.
- Replaces the fixed 16-bit, single-line-size fetch path. Adds configurable cache geometry, variable-latency memory, downstream stall, redirect during refill, and a miss counter.
- Sits between the branch/PC-select logic and the decode stage.

---
 rtl/fetch_cache_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_cache_unit.sv
// Instruction-fetch front end: PC register, direct-mapped I-cache with valid/tag arrays,
// and a LOOKUP/FILL miss FSM that refills whole lines over a req/ack handshake.
module fetch_cache_unit #(
    parameter int ADDR_W         = 16,
    parameter int INSTR_W        = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_LINES      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                                inp_clk,
    input  logic                                inp_reset,
    input  logic                                inp_stall,
    input  logic                                inp_pcSrc,
    input  logic [ADDR_W-1:0]                   inp_branchTarget,
    output logic                                out_mem_req,
    output logic [ADDR_W-1:0]                   out_mem_address,
    input  logic                                inp_mem_ack,
    input  logic [INSTR_W*WORDS_PER_LINE-1:0]   inp_mem_lineData,
    output logic [INSTR_W-1:0]                  out_instruction,
    output logic [ADDR_W-1:0]                   out_pc,
    output logic                                out_valid,
    output logic                                out_hit,
    output logic [15:0]                         out_missCount
);
    localparam int LINE_W = INSTR_W * WORDS_PER_LINE;
    localparam int BYTE_B = $clog2(INSTR_W / 8);
    localparam int WORD_B = $clog2(WORDS_PER_LINE);
    localparam int IDX_B  = $clog2(NUM_LINES);
    localparam int OFF_B  = BYTE_B + WORD_B;
    localparam int TAG_W  = ADDR_W - OFF_B - IDX_B;
    localparam int WSEL_W = (WORD_B > 0) ? WORD_B : 1;
    localparam int IDX_W  = (IDX_B > 0) ? IDX_B : 1;
    localparam logic [ADDR_W-1:0] BYTE_MASK = ~ADDR_W'((1 << BYTE_B) - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_B) - 1);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(INSTR_W / 8);

    typedef enum logic {LOOKUP, FILL} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
    logic [15:0]         miss_count_q, miss_count_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                fill;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem [NUM_LINES];

    logic [WSEL_W-1:0]   word_sel;
    logic [IDX_W-1:0]    index;
    logic [TAG_W-1:0]    tag;
    logic [LINE_W-1:0]   line;
    logic [ADDR_W-1:0]   target;

    // Field extraction by shift + truncating cast so degenerate geometries stay legal.
    assign word_sel = (WORD_B > 0) ? WSEL_W'(pc_q >> BYTE_B) : '0;
    assign index    = (IDX_B > 0) ? IDX_W'(pc_q >> OFF_B) : '0;
    assign tag      = TAG_W'(pc_q >> (OFF_B + IDX_B));
    assign line     = data_mem[index];
    assign target   = inp_branchTarget & BYTE_MASK;

    assign out_hit         = valid_q[index] && (tag_mem[index] == tag);
    assign out_instruction = out_hit ? line[word_sel*INSTR_W +: INSTR_W] : '0;
    assign out_valid       = (state_q == LOOKUP) && out_hit;
    assign out_mem_req     = (state_q == FILL);
    assign out_mem_address = mem_addr_q;
    assign out_pc          = pc_q;
    assign out_missCount   = miss_count_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        miss_count_d = miss_count_q;
        mem_addr_d   = mem_addr_q;
        fill         = 1'b0;
        case (state_q)
            LOOKUP: begin
                if (inp_pcSrc) begin
                    pc_d = target;
                end else if (out_hit) begin
                    if (!inp_stall) pc_d = pc_q + STEP;
                end else begin
                    state_d    = FILL;
                    mem_addr_d = pc_q & LINE_MASK;
                    if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
                end
            end
            FILL: begin
                if (inp_pcSrc) begin
                    pend_d    = 1'b1;
                    pend_pc_d = target;
                end
                if (inp_mem_ack) begin
                    fill    = 1'b1;
                    state_d = LOOKUP;
                    pend_d  = 1'b0;
                    // A redirect arriving with the ack is newer than any pending one.
                    if (inp_pcSrc)   pc_d = target;
                    else if (pend_q) pc_d = pend_pc_q;
                end
            end
            default: state_d = LOOKUP;
        endcase
    end

    always_ff @(posedge inp_clk) begin
        if (inp_reset) begin
            state_q      <= LOOKUP;
            pc_q         <= RESET_PC;
            pend_q       <= 1'b0;
            pend_pc_q    <= '0;
            miss_count_q <= '0;
            mem_addr_q   <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            miss_count_q <= miss_count_d;
            mem_addr_q   <= mem_addr_d;
            if (fill) valid_q[index] <= 1'b1;
        end
    end

    // PC is frozen during FILL, so its index/tag name the line being refilled.
    always_ff @(posedge inp_clk) begin
        if (fill && !inp_reset) begin
            data_mem[index] <= inp_mem_lineData;
            tag_mem[index]  <= tag;
        end
    end
endmodule
